fetch_pc_gen: RTL and testbench

Front-end PC generator and instruction buffer sitting between instruction memory and decode. It consumes the branch unit's resolution stream (valid/redirect/target) and turns each taken redirect into a pipeline flush plus a restart of sequential fetch at the new PC. Stale in-flight memory responses are discarded, and fetched words are queued for decode in a small FIFO.

---
 rtl/fetch_pc_gen.sv | 145 ++++++++++++++
 tb/tb_fetch_pc_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Front-end PC generator with in-order fetch tracking, stale-response dropping and a small decode FIFO.
// Optional FETCH_REDIRECT_BYPASS_EN: issue the redirect target request in the same cycle as the redirect.
module fetch_pc_gen #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_valid_i,
    input  logic        branch_redirect_i,
    input  logic [63:0] branch_redirect_pc_i,
    output logic        flush_o,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [63:0] imem_req_addr_o,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_inst_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [63:0] inst_pc_o,
    output logic [31:0] inst_o
);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DROP_W = PTR_W + 2;
    localparam int unsigned SUM_W  = DROP_W + 1;

    logic [63:0]       r_pc;
    logic [63:0]       r_resp_pc;
    logic              r_started;
    logic [CNT_W-1:0]  r_out_cnt;
    logic [DROP_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0]  r_fifo_cnt;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [63:0]       r_fifo_pc   [DEPTH];
    logic [31:0]       r_fifo_inst [DEPTH];

    logic              w_redirect;
    logic [63:0]       w_target;
    logic              w_credit;
    logic              w_req_fire;
    logic              w_resp_stale;
    logic              w_resp_live;
    logic              w_resp_dec;
    logic              w_push;
    logic              w_pop;
    logic [SUM_W-1:0]  w_drop_sum;
    logic [DROP_W-1:0] w_drop_redir;
    logic              w_unused_lsbs;

    assign w_redirect    = branch_valid_i & branch_redirect_i;
    assign w_target      = {branch_redirect_pc_i[63:2], 2'b00};
    assign w_unused_lsbs = ^branch_redirect_pc_i[1:0];
    assign flush_o       = w_redirect;

    // Live outstanding requests reserve FIFO slots so a response always has room.
    assign w_credit = ((CNT_W+1)'(r_fifo_cnt) + (CNT_W+1)'(r_out_cnt)) < (CNT_W+1)'(DEPTH);

`ifdef FETCH_REDIRECT_BYPASS_EN
    assign imem_req_valid_o = r_started & (w_redirect | w_credit);
    assign imem_req_addr_o  = w_redirect ? w_target : r_pc;
`else
    assign imem_req_valid_o = r_started & w_credit & ~w_redirect;
    assign imem_req_addr_o  = r_pc;
`endif

    assign w_req_fire   = imem_req_valid_o & imem_req_ready_i;
    assign w_resp_stale = imem_resp_valid_i & (r_drop_cnt != '0);
    assign w_resp_live  = imem_resp_valid_i & (r_drop_cnt == '0);
    assign w_push       = w_resp_live & ~w_redirect;
    assign w_pop        = (r_fifo_cnt != '0) & inst_ready_i;

    // Everything in flight becomes stale on redirect; a response this cycle retires one of them.
    assign w_resp_dec   = imem_resp_valid_i & ((r_drop_cnt != '0) | (r_out_cnt != '0));
    assign w_drop_sum   = SUM_W'(r_drop_cnt) + SUM_W'(r_out_cnt) - SUM_W'(w_resp_dec);
    assign w_drop_redir = (w_drop_sum > SUM_W'(2 * DEPTH)) ? DROP_W'(2 * DEPTH)
                                                           : w_drop_sum[DROP_W-1:0];

    assign inst_valid_o = (r_fifo_cnt != '0);
    assign inst_pc_o    = r_fifo_pc[r_rd_ptr];
    assign inst_o       = r_fifo_inst[r_rd_ptr];

    // Fetch address, response PC tracking and outstanding/stale counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_started  <= 1'b0;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_started <= 1'b1;
            if (w_redirect) begin
                r_pc       <= w_req_fire ? (w_target + 64'd4) : w_target;
                r_resp_pc  <= w_target;
                r_out_cnt  <= w_req_fire ? CNT_W'(1) : '0;
                r_drop_cnt <= w_drop_redir;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 64'd4;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 64'd4;
                end
                r_out_cnt  <= r_out_cnt + CNT_W'(w_req_fire) - CNT_W'(w_resp_live);
                r_drop_cnt <= r_drop_cnt - DROP_W'(w_resp_stale);
            end
        end
    end

    // Instruction buffer pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else if (w_redirect) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Instruction buffer storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]   <= '0;
                r_fifo_inst[i] <= '0;
            end
        end else if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
            r_fifo_inst[r_wr_ptr] <= imem_resp_inst_i;
        end
    end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: behavioural in-order memory with programmable latency.
module tb_fetch_pc_gen;
    logic        clk;
    logic        rst_n;
    logic        branch_valid_i;
    logic        branch_redirect_i;
    logic [63:0] branch_redirect_pc_i;
    logic        flush_o;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [63:0] imem_req_addr_o;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_inst_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [63:0] inst_pc_o;
    logic [31:0] inst_o;

    int n_checks = 0;
    int n_pass   = 0;
    int mem_cyc  = 0;
    int mem_lat  = 1;
    int req_cnt  = 0;

`ifdef FETCH_REDIRECT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    fetch_pc_gen dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .branch_valid_i       (branch_valid_i),
        .branch_redirect_i    (branch_redirect_i),
        .branch_redirect_pc_i (branch_redirect_pc_i),
        .flush_o              (flush_o),
        .imem_req_valid_o     (imem_req_valid_o),
        .imem_req_ready_i     (imem_req_ready_i),
        .imem_req_addr_o      (imem_req_addr_o),
        .imem_resp_valid_i    (imem_resp_valid_i),
        .imem_resp_inst_i     (imem_resp_inst_i),
        .inst_valid_o         (inst_valid_o),
        .inst_ready_i         (inst_ready_i),
        .inst_pc_o            (inst_pc_o),
        .inst_o               (inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Memory: accept at negedge, answer in order once the latency has elapsed.
    always @(negedge clk) begin
        if (rst_n && imem_req_valid_o && imem_req_ready_i) begin
            mreq_t e;
            e.addr = imem_req_addr_o;
            e.due  = mem_cyc + mem_lat;
            mq.push_back(e);
            req_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        mem_cyc++;
        if (!rst_n) begin
            mq.delete();
            imem_resp_valid_i = 1'b0;
            imem_resp_inst_i  = '0;
        end else if (mq.size() != 0 && mq[0].due <= mem_cyc) begin
            imem_resp_valid_i = 1'b1;
            imem_resp_inst_i  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_resp_valid_i = 1'b0;
            imem_resp_inst_i  = '0;
        end
    end

    // Whatever decode takes must carry the word stored at its PC.
    always @(negedge clk) begin
        if (rst_n && inst_valid_o && inst_ready_i)
            check("dec_word", 64'(inst_o), 64'(mem_word(inst_pc_o)));
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n                = 1'b0;
        branch_valid_i       = 1'b0;
        branch_redirect_i    = 1'b0;
        branch_redirect_pc_i = '0;
        imem_req_ready_i     = 1'b1;
        inst_ready_i         = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst_n   = 1'b1;
        req_cnt = 0;
        #1;
    endtask

    task automatic redirect(input logic [63:0] pc);
        branch_valid_i       = 1'b1;
        branch_redirect_i    = 1'b1;
        branch_redirect_pc_i = pc;
    endtask

    task automatic no_branch();
        branch_valid_i    = 1'b0;
        branch_redirect_i = 1'b0;
    endtask

    initial begin
        rst_n                = 1'b0;
        branch_valid_i       = 1'b0;
        branch_redirect_i    = 1'b0;
        branch_redirect_pc_i = '0;
        imem_req_ready_i     = 1'b1;
        inst_ready_i         = 1'b0;
        imem_resp_valid_i    = 1'b0;
        imem_resp_inst_i     = '0;
        #12;
        check("rst_flush",     64'(flush_o), 64'd0);
        check("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
        check("rst_req_addr",  imem_req_addr_o, 64'h0000_0000_8000_0000);
        check("rst_inst_valid", 64'(inst_valid_o), 64'd0);
        check("rst_inst_pc",   inst_pc_o, 64'd0);
        check("rst_inst",      64'(inst_o), 64'd0);

        // Sequential fetch with 1-cycle memory, plus a not-taken branch.
        mem_lat = 1;
        do_reset();
        check("t1_c0_req_valid", 64'(imem_req_valid_o), 64'd0);
        adv(); #2;
        check("t1_c1_req_valid", 64'(imem_req_valid_o), 64'd1);
        check("t1_c1_addr", imem_req_addr_o, 64'h8000_0000);
        adv(); #2;
        check("t1_c2_addr", imem_req_addr_o, 64'h8000_0004);
        check("t1_c2_inst_valid", 64'(inst_valid_o), 64'd0);
        adv(); #2;
        check("t1_c3_addr", imem_req_addr_o, 64'h8000_0008);
        check("t1_c3_inst_valid", 64'(inst_valid_o), 64'd1);
        check("t1_c3_inst_pc", inst_pc_o, 64'h8000_0000);
        check("t1_c3_inst", 64'(inst_o), 64'(mem_word(64'h8000_0000)));
        adv(); #2;
        check("t1_c4_inst_pc", inst_pc_o, 64'h8000_0004);
        adv();
        branch_valid_i       = 1'b1;
        branch_redirect_i    = 1'b0;
        branch_redirect_pc_i = 64'h1234_0000;
        #2;
        check("t1_c5_flush", 64'(flush_o), 64'd0);
        check("t1_c5_addr", imem_req_addr_o, 64'h8000_0010);
        check("t1_c5_inst_pc", inst_pc_o, 64'h8000_0008);
        adv(); no_branch(); #2;
        check("t1_c6_addr", imem_req_addr_o, 64'h8000_0014);
        check("t1_c6_inst_pc", inst_pc_o, 64'h8000_000C);

        // Decode stalled: request credit limits to DEPTH, then drains in order.
        mem_lat = 1;
        do_reset();
        inst_ready_i = 1'b0;
        repeat (5) adv();
        #2;
        check("t2_c5_req_valid", 64'(imem_req_valid_o), 64'd0);
        adv(); #2;
        check("t2_c6_req_valid", 64'(imem_req_valid_o), 64'd0);
        check("t2_c6_inst_valid", 64'(inst_valid_o), 64'd1);
        check("t2_c6_inst_pc", inst_pc_o, 64'h8000_0000);
        adv(); inst_ready_i = 1'b1; #2;
        check("t2_c7_req_cnt", 64'(req_cnt), 64'd4);
        check("t2_c7_req_valid", 64'(imem_req_valid_o), 64'd0);
        check("t2_c7_inst_pc", inst_pc_o, 64'h8000_0000);
        adv(); #2;
        check("t2_c8_inst_pc", inst_pc_o, 64'h8000_0004);
        check("t2_c8_req_valid", 64'(imem_req_valid_o), 64'd1);
        check("t2_c8_addr", imem_req_addr_o, 64'h8000_0010);
        adv(); #2;
        check("t2_c9_inst_pc", inst_pc_o, 64'h8000_0008);
        adv(); #2;
        check("t2_c10_inst_pc", inst_pc_o, 64'h8000_000C);
        adv(); #2;
        check("t2_c11_inst_pc", inst_pc_o, 64'h8000_0010);
        check("t2_c11_inst", 64'(inst_o), 64'(mem_word(64'h8000_0010)));

        // 3-cycle memory, redirect with one buffered entry and two live requests.
        mem_lat = 3;
        do_reset();
        inst_ready_i = 1'b0;
        repeat (3) adv();
        adv(); imem_req_ready_i = 1'b0; #2;
        check("t3_c4_req_valid", 64'(imem_req_valid_o), 64'd1);
        adv(); imem_req_ready_i = 1'b1; redirect(64'h8000_1002); #2;
        check("t3_c5_flush", 64'(flush_o), 64'd1);
        check("t3_c5_inst_valid", 64'(inst_valid_o), 64'd1);
        check("t3_c5_req_valid", 64'(imem_req_valid_o), 64'(BYP));
        if (BYP) check("t3_c5_addr", imem_req_addr_o, 64'h8000_1000);
        adv(); no_branch(); inst_ready_i = 1'b1; #2;
        check("t3_c6_flush", 64'(flush_o), 64'd0);
        check("t3_c6_inst_valid", 64'(inst_valid_o), 64'd0);
        check("t3_c6_req_valid", 64'(imem_req_valid_o), 64'd1);
        check("t3_c6_addr", imem_req_addr_o, BYP ? 64'h8000_1004 : 64'h8000_1000);
        adv(); #2;
        check("t3_c7_inst_valid", 64'(inst_valid_o), 64'd0);
        check("t3_c7_addr", imem_req_addr_o, BYP ? 64'h8000_1008 : 64'h8000_1004);
        adv(); #2;
        check("t3_c8_inst_valid", 64'(inst_valid_o), 64'd0);
        adv(); #2;
        check("t3_c9_inst_valid", 64'(inst_valid_o), 64'(BYP));
        adv(); #2;
        check("t3_c10_inst_valid", 64'(inst_valid_o), 64'd1);
        check("t3_c10_inst_pc", inst_pc_o, BYP ? 64'h8000_1004 : 64'h8000_1000);

        // Back-to-back redirects: only the second target survives.
        mem_lat = 3;
        do_reset();
        repeat (2) adv();
        adv(); redirect(64'h100); #2;
        check("t4_c3_flush", 64'(flush_o), 64'd1);
        check("t4_c3_req_valid", 64'(imem_req_valid_o), 64'(BYP));
        if (BYP) check("t4_c3_addr", imem_req_addr_o, 64'h100);
        adv(); redirect(64'h200); #2;
        check("t4_c4_flush", 64'(flush_o), 64'd1);
        check("t4_c4_req_valid", 64'(imem_req_valid_o), 64'(BYP));
        if (BYP) check("t4_c4_addr", imem_req_addr_o, 64'h200);
        adv(); no_branch(); #2;
        check("t4_c5_flush", 64'(flush_o), 64'd0);
        check("t4_c5_addr", imem_req_addr_o, BYP ? 64'h204 : 64'h200);
        check("t4_c5_inst_valid", 64'(inst_valid_o), 64'd0);
        adv(); #2;
        check("t4_c6_inst_valid", 64'(inst_valid_o), 64'd0);
        adv(); #2;
        check("t4_c7_inst_valid", 64'(inst_valid_o), 64'd0);
        adv(); #2;
        check("t4_c8_inst_valid", 64'(inst_valid_o), 64'(BYP));
        if (BYP) check("t4_c8_inst_pc", inst_pc_o, 64'h200);
        adv(); #2;
        check("t4_c9_inst_valid", 64'(inst_valid_o), 64'd1);
        check("t4_c9_inst_pc", inst_pc_o, BYP ? 64'h204 : 64'h200);

        // Redirect to 0x4000 mid-stream with 1-cycle memory.
        mem_lat = 1;
        do_reset();
        repeat (3) adv();
        adv(); redirect(64'h4000); #2;
        check("t5_c4_flush", 64'(flush_o), 64'd1);
        check("t5_c4_req_valid", 64'(imem_req_valid_o), 64'(BYP));
        if (BYP) check("t5_c4_addr", imem_req_addr_o, 64'h4000);
        adv(); no_branch(); #2;
        check("t5_c5_inst_valid", 64'(inst_valid_o), 64'd0);
        check("t5_c5_req_valid", 64'(imem_req_valid_o), 64'd1);
        check("t5_c5_addr", imem_req_addr_o, BYP ? 64'h4004 : 64'h4000);
        adv(); #2;
        check("t5_c6_inst_valid", 64'(inst_valid_o), 64'(BYP));
        if (BYP) check("t5_c6_inst_pc", inst_pc_o, 64'h4000);
        adv(); #2;
        check("t5_c7_inst_valid", 64'(inst_valid_o), 64'd1);
        check("t5_c7_inst_pc", inst_pc_o, BYP ? 64'h4004 : 64'h4000);
        adv(); #2;
        check("t5_c8_inst_pc", inst_pc_o, BYP ? 64'h4008 : 64'h4004);

        adv();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
